// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: run control, redirect/stall from downstream, program-load
// port, and the fetched instruction/PC handed to the IF/ID register.
interface if_fetch_unit_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8
);
  logic               start;
  logic               stall;
  logic               jump_en;
  logic [PC_W-1:0]    jump_target;
  logic               prog_we;
  logic [PC_W-1:0]    prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic [INSTR_W-1:0] instrCode;
  logic [PC_W-1:0]    pc;
  logic               flush;
  logic               halted;

  // Requester side: drives control/program, observes fetch output.
  modport master (
    output start, stall, jump_en, jump_target, prog_we, prog_addr, prog_data,
    input  instrCode, pc, flush, halted
  );

  // Fetch unit side.
  modport slave (
    input  start, stall, jump_en, jump_target, prog_we, prog_addr, prog_data,
    output instrCode, pc, flush, halted
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC register, loadable instruction memory and an
// IDLE/RUN/HALT run-control FSM. A redirect raises flush combinationally so
// the IF/ID register drops the single wrong-path instruction.
module if_fetch_unit #(
  parameter int                 PC_W      = 8,
  parameter int                 INSTR_W   = 8,
  parameter int                 MEM_DEPTH = 32,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] HALT_OP   = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  if_fetch_unit_if.slave    bus
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // Address mask; MEM_DEPTH is a power of two so this keeps the low AW bits.
  localparam logic [PC_W-1:0] PC_MASK = PC_W'(MEM_DEPTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]                        r_state;
  logic [1:0]                        w_state_nxt;
  logic [PC_W-1:0]                   r_pc;
  logic [PC_W-1:0]                   w_pc_nxt;
  logic [MEM_DEPTH-1:0][INSTR_W-1:0] r_mem;
  logic [INSTR_W-1:0]                w_rd;
  logic [AW-1:0]                     w_rd_idx;
  logic [AW-1:0]                     w_wr_idx;
  logic                              w_run;
  logic                              w_mem_we;

  assign w_run    = (r_state == S_RUN);
  assign w_rd_idx = r_pc[AW-1:0];
  assign w_wr_idx = bus.prog_addr[AW-1:0];
  assign w_rd     = r_mem[w_rd_idx];
  // Program loading is only honoured while idle and out of reset.
  assign w_mem_we = rst && (r_state == S_IDLE) && bus.prog_we;

  // Upper address bits beyond the memory depth are intentionally dropped.
  generate
    if (PC_W > AW) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^bus.prog_addr[PC_W-1:AW];
    end
  endgenerate

  // Next-state / next-PC: redirect beats stall beats halt detect beats increment.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (bus.jump_en) begin
          w_pc_nxt = bus.jump_target & PC_MASK;
        end else if (bus.stall) begin
          w_pc_nxt = r_pc;
        end else if (w_rd == HALT_OP) begin
          w_state_nxt = S_HALT;
        end else begin
          w_pc_nxt = (r_pc == PC_MASK) ? '0 : ((r_pc + 1'b1) & PC_MASK);
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Run-control state and PC; reset aborts fetch immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC & PC_MASK;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Instruction memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_wr_idx] <= bus.prog_data;
  end

  // Outputs: instruction only valid in RUN, flush only on a RUN redirect.
  assign bus.instrCode = w_run ? w_rd : '0;
  assign bus.pc        = r_pc;
  assign bus.flush     = w_run && bus.jump_en;
  assign bus.halted    = (r_state == S_HALT);

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction fetch stage of the 8-bit pipelined processor; drives instrCode/pc into the IF/ID pipeline register.
- Holds the PC, a small loadable instruction memory, and a run-control FSM (IDLE/RUN/HALT).
- Accepts stall and jump redirect from downstream; a redirect asserts flush so IF/ID discards the wrong-path instruction.

Parameters:
- PC_W, 8, PC and address width.
- INSTR_W, 8, instruction width.
- MEM_DEPTH, 32, instruction memory words; power of 2, at most 2^PC_W.
- RESET_PC, 0, PC value after reset; must be below MEM_DEPTH.
- HALT_OP, 8'hFF, opcode that halts fetch.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  IDLE->RUN request.
- stall  in  1  hold PC (hazard unit).
- jump_en  in  1  redirect request from ID stage.
- jump_target  in  PC_W  redirect address.
- prog_we  in  1  instruction memory write enable (IDLE only).
- prog_addr  in  PC_W  write address; low log2(MEM_DEPTH) bits used.
- prog_data  in  INSTR_W  write data.
- instrCode  out  INSTR_W  fetched instruction to IF/ID.
- pc  out  PC_W  PC of instrCode.
- flush  out  1  clear IF/ID this cycle.
- halted  out  1  FSM in HALT.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=IDLE, flush=0, halted=0. Memory contents are not cleared. Reset mid-run aborts immediately.
- Memory: synchronous write, combinational read of mem[pc].
- pc register always holds a value masked to MEM_DEPTH-1.
- IDLE:
  - instrCode=0; pc holds; flush=0.
  - prog_we writes mem[prog_addr] on the clock edge.
  - stall and jump_en are ignored.
  - start=1 -> RUN next cycle.
- RUN:
  - instrCode=mem[pc].
  - prog_we and start are ignored.
  - Priority per cycle: jump_en > stall > halt detect > increment.
  - jump_en=1: flush=1 in the same cycle (combinational). Next pc = jump_target & (MEM_DEPTH-1). State stays RUN.
  - Else stall=1: pc holds; instrCode is re-presented.
  - Else instrCode==HALT_OP: pc holds; state -> HALT.
  - Else increment: next pc = (pc==MEM_DEPTH-1) ? 0 : pc+1.
- HALT:
  - instrCode=0; pc holds; halted=1; flush=0.
  - All inputs are ignored. Only reset exits HALT.
- Latency: a redirect takes effect in 1 cycle. The single wrong-path instruction is removed by flush.

Test Plan:
- Reset, load mem[0..3]={11,22,33,FF}, pulse start -> pc/instrCode 0/11, 1/22, 2/33, 3/FF on consecutive cycles; next cycle halted=1, pc=3, instrCode=00, held for 5 cycles.
- Same program, stall=1 for 2 cycles while pc=1 -> pc=1, instrCode=22 for 3 cycles, then pc=2.
- mem[16]=5A, jump_en=1 with target 10h while pc=2 and stall=1 -> flush=1 that cycle (jump beats stall); next cycle pc=10h, instrCode=5A, flush=0.
- Jump to 1Fh, no stall -> pc 1F then 00 (wrap). jump_target=28h (40) -> pc=08h.
- prog_we=1, prog_addr=0, prog_data=77 while in RUN -> mem[0] unchanged (still 11) after a later jump to 0.
- Assert rst=0 asynchronously mid-RUN at pc=2 -> pc=0, halted=0, flush=0 with no clock edge; release, pulse start -> refetch from 0 with instrCode 11 (memory retained).
